asyn_fifo_wr_framer: RTL
========================

ASYN_FIFO_WR_FRAMER -- requirements
Module: asyn_fifo_wr_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data byte width.
REQ-002 The block SHALL have parameter MAX_LEN, default 64, giving the maximum number of payload words per frame (minimum 2).
REQ-003 The block SHALL have parameter SOF, default 8'hA5, giving the header word value.
REQ-004 The block SHALL have port wclk, input, 1 bit: write-domain clock; all logic is rising-edge.
REQ-005 The block SHALL have port wrstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: upstream word accepted when in_valid and in_ready are both high.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: payload word.
REQ-009 The block SHALL have port in_last, input, 1 bit: marks the final payload word of a frame.
REQ-010 The block SHALL have port wfull, input, 1 bit: full flag from the async FIFO write side.
REQ-011 The block SHALL have port winc, output, 1 bit: FIFO write strobe.
REQ-012 The block SHALL have port wdata, output, WIDTH bits: FIFO write data.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have port frame_cnt, output, 16 bits: count of completed frames.
REQ-015 The block SHALL have port trunc_err, output, 1 bit: one-cycle pulse on frame truncation.

Function
REQ-016 The FSM SHALL have states IDLE, HDR, DATA, CSUM and DROP.
REQ-017 IDLE: in_ready=0, winc=0, wdata=0; on in_valid=1 the FSM SHALL go to HDR without consuming the word.
REQ-018 HDR: wdata=SOF, winc=!wfull; when winc=1 the FSM SHALL go to DATA, clearing the checksum and length counter to 0.
REQ-019 DATA: in_ready=!wfull, winc=in_valid&!wfull, wdata=in_data (combinational pass-through, zero latency).
REQ-020 Each DATA transfer SHALL update checksum ^= in_data and increment the length counter (width clog2(MAX_LEN)+1).
REQ-021 DATA transfer with in_last=1 SHALL go to CSUM with trunc flag cleared.
REQ-022 DATA transfer that is the MAX_LEN-th word with in_last=0 SHALL go to CSUM, set the trunc flag, and pulse trunc_err for one cycle.
REQ-023 The MAX_LEN-th word with in_last=1 SHALL be treated as a normal end of frame, with no truncation.
REQ-024 CSUM: wdata=checksum when trunc=0 and ~checksum when trunc=1; winc=!wfull.
REQ-025 On the CSUM write, frame_cnt SHALL increment (wrapping 16'hFFFF->0), and the FSM SHALL go to DROP if trunc=1, else to IDLE.
REQ-026 DROP: in_ready=1, winc=0; words SHALL be discarded; on in_valid&in_last the FSM SHALL go to IDLE.
REQ-027 winc SHALL never be high while wfull=1; a stalled word (wfull=1) SHALL be held, never dropped or duplicated.
REQ-028 Back-to-back frames SHALL have exactly one IDLE cycle between the CSUM write and the HDR write.
REQ-029 in_valid deasserted mid-frame in DATA SHALL produce no write and no state change.

Reset
REQ-030 While wrstn=0: state=IDLE, checksum=0, length=0, trunc=0, frame_cnt=0, trunc_err=0, winc=0, in_ready=0, wdata=0, busy=0.
REQ-031 Reset asserted mid-frame SHALL abandon the partial frame with no further winc; after release the next frame SHALL start cleanly at HDR.

Verification
REQ-032 Frame 01,02,04 (last on 04), wfull=0 -> winc high for 5 consecutive cycles writing A5,01,02,04,07; frame_cnt=1; busy low afterwards.
REQ-033 Single-word frame 5A with last -> writes A5,5A,5A.
REQ-034 wfull=1 for 3 cycles during DATA -> in_ready=0 and winc=0 for those cycles; resumed sequence identical to REQ-032 with no loss or duplication.
REQ-035 MAX_LEN=4, 6-word frame 10,20,30,40,50,60 (last on 60) -> writes A5,10,20,30,40,BF; trunc_err pulses once; 50,60 consumed with no winc; the next frame is normal.
REQ-036 wrstn pulsed low after 2 DATA words -> winc=0 immediately, frame_cnt=0; a following frame of 01,02,04 writes A5,01,02,04,07.
REQ-037 Two frames with in_valid held continuously -> one idle cycle between frames; frame_cnt=2; checksums are independent.

Source files
------------

// File: rtl/asyn_fifo_wr_framer.sv
// Write-side framer for an async FIFO: wraps each upstream frame as SOF, payload, XOR checksum.
// Frames longer than MAX_LEN are cut short, flagged with an inverted checksum, and their tail dropped.
`timescale 1ns/1ps

module asyn_fifo_wr_framer #(
  parameter int              WIDTH   = 8,
  parameter int              MAX_LEN = 64,
  parameter logic [WIDTH-1:0] SOF    = 8'hA5
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             wfull,
  output logic             winc,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic             trunc_err
);

  localparam int LW = $clog2(MAX_LEN) + 1;

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DROP} state_t;

  state_t           state;
  logic [WIDTH-1:0] csum;
  logic [LW-1:0]    len;
  logic             trunc;
  logic             last_slot;

  assign last_slot = (len == LW'(MAX_LEN - 1));
  assign busy      = (state != IDLE);

  // FIFO-facing strobes are combinational so payload words pass through with zero latency.
  always_comb begin
    in_ready = 1'b0;
    winc     = 1'b0;
    wdata    = '0;
    case (state)
      HDR: begin
        wdata = SOF;
        winc  = !wfull;
      end
      DATA: begin
        in_ready = !wfull;
        winc     = in_valid && !wfull;
        wdata    = in_data;
      end
      CSUM: begin
        wdata = trunc ? ~csum : csum;
        winc  = !wfull;
      end
      DROP: in_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state     <= IDLE;
      csum      <= '0;
      len       <= '0;
      trunc     <= 1'b0;
      frame_cnt <= 16'd0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: if (in_valid) state <= HDR;
        HDR: begin
          if (!wfull) begin
            state <= DATA;
            csum  <= '0;
            len   <= '0;
          end
        end
        DATA: begin
          if (in_valid && !wfull) begin
            csum <= csum ^ in_data;
            len  <= len + LW'(1);
            // An explicit last on the final allowed slot is a clean end, not a truncation.
            if (in_last) begin
              trunc <= 1'b0;
              state <= CSUM;
            end else if (last_slot) begin
              trunc     <= 1'b1;
              trunc_err <= 1'b1;
              state     <= CSUM;
            end
          end
        end
        CSUM: begin
          if (!wfull) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= trunc ? DROP : IDLE;
          end
        end
        DROP: if (in_valid && in_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
